alu_mul_seq: RTL

- Iterative shift-add multiplier controller. It sequences the shared 32-bit combinational ALU to compute the low XLEN bits of an unsigned product, which is RV32 MUL semantics.
- Sits beside the ALU in the execute stage. It owns the ALU operand and control inputs while busy; the surrounding mux hands them back when Busy is low.
- Requester side uses a valid/ready request channel and a valid/ready response channel.

---
 rtl/alu_mul_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier that borrows the execute-stage ALU to form the low XLEN bits of MulA*MulB.
// Optional early termination is compiled in with `define MUL_SEQ_EARLY_EXIT_EN.
module alu_mul_seq #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ReqValid,
  output logic            ReqReady,
  input  logic [XLEN-1:0] MulA,
  input  logic [XLEN-1:0] MulB,
  output logic            RespValid,
  input  logic            RespReady,
  output logic [XLEN-1:0] Product,
  output logic            Busy,
  output logic [XLEN-1:0] AluSrcA,
  output logic [XLEN-1:0] AluSrcB,
  output logic [2:0]      AluControl,
  input  logic [XLEN-1:0] AluResult
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0]       ALU_ADD  = 3'b000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t            state_q;
  state_t            state_d;
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;
  logic [CNT_W-1:0]  count;
  logic              last_step;
  logic              zero_req;

  // The final step is either the XLEN-th iteration or, with early exit,
  // the step that consumes the last set multiplier bit.
`ifdef MUL_SEQ_EARLY_EXIT_EN
  assign last_step = (count == CNT_LAST) || ((mplier >> 1) == '0);
  assign zero_req  = (MulB == '0);
`else
  assign last_step = (count == CNT_LAST);
  assign zero_req  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ReqReady   = 1'b0;
    RespValid  = 1'b0;
    Busy       = 1'b0;
    AluSrcA    = '0;
    AluSrcB    = '0;
    AluControl = ALU_ADD;
    case (state_q)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          state_d = zero_req ? DONE : RUN;
        end
      end
      RUN: begin
        Busy    = 1'b1;
        AluSrcA = acc;
        AluSrcB = mplier[0] ? mcand : '0;
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        RespValid = 1'b1;
        if (RespReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      Product <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (ReqValid) begin
            mcand  <= MulA;
            mplier <= MulB;
            acc    <= '0;
            count  <= '0;
            if (zero_req) begin
              Product <= '0;
            end
          end
        end
        RUN: begin
          // ALU add wraps mod 2^XLEN; carries past XLEN are not needed for MUL.
          acc    <= AluResult;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
          if (last_step) begin
            Product <= AluResult;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
